// File: rtl/word_guess_controller_pkg.sv
// Shared definitions for the word-guess controller: FSM encoding, per-letter
// score codes and the default letter width.
package word_guess_controller_pkg;

  // Default width of one letter code.
  localparam int LETTER_W_DEF = 6;

  // Game state machine encoding.
  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_CHECK = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_e;

  // Per-position score codes; three of these pack into the 6-bit result,
  // position 1 in the top two bits.
  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_PRESENT = 2'b01;
  localparam logic [1:0] RES_EXACT   = 2'b10;

  // Result word for a fully correct guess.
  localparam logic [5:0] RES_ALL_EXACT = {RES_EXACT, RES_EXACT, RES_EXACT};

  // Saturating increment used for the 3-bit attempt counter.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    sat_inc3 = (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

endpackage

// File: rtl/word_guess_controller_guess_scorer.sv
// Purely combinational scorer: compares a 3-letter guess with the target and
// produces a 2-bit code per position (miss / present elsewhere / exact).
// Letter order in both words: position 1 in the most significant slice.
module guess_scorer
  import word_guess_controller_pkg::*;
#(
  parameter int LETTER_W = LETTER_W_DEF
) (
  input  logic [3*LETTER_W-1:0] guess,
  input  logic [3*LETTER_W-1:0] target,
  output logic [5:0]            result
);

  logic [LETTER_W-1:0] g [3];
  logic [LETTER_W-1:0] t [3];
  logic [2:0]          exact;
  logic [2:0]          present;

  // Unpack letters and flag exact matches; index 0 is position 1.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      g[i]     = guess[(2-i)*LETTER_W +: LETTER_W];
      t[i]     = target[(2-i)*LETTER_W +: LETTER_W];
      exact[i] = (g[i] == t[i]);
    end
  end

  // A letter is "present" when it matches some other position of the target
  // that is not itself already claimed by an exact match.
  always_comb begin
    present = 3'b000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ((j != i) && !exact[i] && !exact[j] && (g[i] == t[j])) begin
          present[i] = 1'b1;
        end
      end
    end
  end

  // Pack the per-position codes, exact taking precedence over present.
  always_comb begin
    result = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      if (exact[i]) begin
        result[(2-i)*2 +: 2] = RES_EXACT;
      end else if (present[i]) begin
        result[(2-i)*2 +: 2] = RES_PRESENT;
      end else begin
        result[(2-i)*2 +: 2] = RES_MISS;
      end
    end
  end

endmodule

// File: rtl/word_guess_controller.sv
// Word-guess game controller. Turns debounced button levels into single-cycle
// decoder commands (en / del / clr), tracks how many letters the decoder
// holds, scores a submitted guess and runs the ENTRY/CHECK/WIN/LOSE game FSM.
//
// Handshake: there is no valid/ready flow control. Each button is a level;
// its rising edge (level high now, low last cycle) is one request, taken in
// the cycle it is seen. Every output is registered, so a request seen in
// cycle n shows its effect in cycle n+1. dec_en, dec_del and dec_clr are
// one-cycle pulses and at most one of them is high in any cycle.
module word_guess_controller
  import word_guess_controller_pkg::*;
#(
  parameter int MAX_GUESSES = 6,
  parameter int LETTER_W    = LETTER_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_en,
  input  logic                  btn_del,
  input  logic                  btn_submit,
  input  logic [LETTER_W-1:0]   letter1,
  input  logic [LETTER_W-1:0]   letter2,
  input  logic [LETTER_W-1:0]   letter3,
  input  logic [3*LETTER_W-1:0] target_word,
  output logic                  dec_en,
  output logic                  dec_del,
  output logic                  dec_clr,
  output logic [1:0]            letter_count,
  output logic [5:0]            result,
  output logic [2:0]            guess_num,
  output logic                  win,
  output logic                  lose
);

  state_e     state_q, state_d;
  logic       en_prev_q, del_prev_q, sub_prev_q;
  logic       dec_en_q, dec_en_d;
  logic       dec_del_q, dec_del_d;
  logic       dec_clr_q, dec_clr_d;
  logic [1:0] count_q, count_d;
  logic [5:0] result_q, result_d;
  logic [2:0] guess_q, guess_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;

  logic       en_edge, del_edge, sub_edge;
  logic [5:0] score;
  logic [2:0] guess_inc;

  // Rising-edge detection against last cycle's button levels.
  assign en_edge  = btn_en     & ~en_prev_q;
  assign del_edge = btn_del    & ~del_prev_q;
  assign sub_edge = btn_submit & ~sub_prev_q;

  assign guess_inc = sat_inc3(guess_q);

  guess_scorer #(
    .LETTER_W (LETTER_W)
  ) u_scorer (
    .guess  ({letter1, letter2, letter3}),
    .target (target_word),
    .result (score)
  );

  // State, history and all output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ENTRY;
      en_prev_q  <= 1'b0;
      del_prev_q <= 1'b0;
      sub_prev_q <= 1'b0;
      dec_en_q   <= 1'b0;
      dec_del_q  <= 1'b0;
      dec_clr_q  <= 1'b0;
      count_q    <= 2'd0;
      result_q   <= 6'd0;
      guess_q    <= 3'd0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= btn_en;
      del_prev_q <= btn_del;
      sub_prev_q <= btn_submit;
      dec_en_q   <= dec_en_d;
      dec_del_q  <= dec_del_d;
      dec_clr_q  <= dec_clr_d;
      count_q    <= count_d;
      result_q   <= result_d;
      guess_q    <= guess_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_d   = state_q;
    dec_en_d  = 1'b0;
    dec_del_d = 1'b0;
    dec_clr_d = 1'b0;
    count_d   = count_q;
    result_d  = result_q;
    guess_d   = guess_q;
    win_d     = win_q;
    lose_d    = lose_q;

    unique case (state_q)
      ST_ENTRY: begin
        // Submit of a full guess takes priority; otherwise delete beats enter.
        if (sub_edge && (count_q == 2'd3)) begin
          state_d = ST_CHECK;
        end else if (del_edge) begin
          if (count_q != 2'd0) begin
            dec_del_d = 1'b1;
            count_d   = count_q - 2'd1;
          end
        end else if (en_edge && (count_q != 2'd3)) begin
          dec_en_d = 1'b1;
          count_d  = count_q + 2'd1;
        end
      end

      ST_CHECK: begin
        // Single-cycle scoring state; letters are stable here.
        result_d = score;
        guess_d  = guess_inc;
        if (score == RES_ALL_EXACT) begin
          state_d = ST_WIN;
          win_d   = 1'b1;
        end else if (guess_inc == 3'(MAX_GUESSES)) begin
          state_d = ST_LOSE;
          lose_d  = 1'b1;
        end else begin
          state_d   = ST_ENTRY;
          dec_clr_d = 1'b1;
          count_d   = 2'd0;
        end
      end

      ST_WIN, ST_LOSE: begin
        // Game over: only submit (new game) is honoured.
        if (sub_edge) begin
          state_d   = ST_ENTRY;
          dec_clr_d = 1'b1;
          count_d   = 2'd0;
          guess_d   = 3'd0;
          result_d  = 6'd0;
          win_d     = 1'b0;
          lose_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_ENTRY;
      end
    endcase
  end

  assign dec_en       = dec_en_q;
  assign dec_del      = dec_del_q;
  assign dec_clr      = dec_clr_q;
  assign letter_count = count_q;
  assign result       = result_q;
  assign guess_num    = guess_q;
  assign win          = win_q;
  assign lose         = lose_q;

endmodule

// File: doc/word_guess_controller.md
Name: word_guess_controller

Overview:
- Sequences the 3-letter entry buffer (letter_decoder) for the word-guessing game.
- Converts button levels into single-cycle en/del/clear pulses and tracks the filled letter count.
- On submit, scores the 3-letter guess against a target word and counts attempts.
- Runs the win/lose state machine; sits between the board buttons/switch logic and the decoder/display.

Parameters:
- MAX_GUESSES, 6, attempts allowed before LOSE (1..7).
- LETTER_W, 6, bits per letter code.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_en  in  1  synchronised, debounced enter-letter level
- btn_del  in  1  synchronised, debounced delete level
- btn_submit  in  1  synchronised, debounced submit / new-game level
- letter1, letter2, letter3  in  LETTER_W each  current decoder contents
- target_word  in  3*LETTER_W  [17:12]=pos1, [11:6]=pos2, [5:0]=pos3; stable during a game
- dec_en  out  1  one-cycle pulse to decoder en
- dec_del  out  1  one-cycle pulse to decoder del
- dec_clr  out  1  one-cycle pulse clearing the decoder
- letter_count  out  2  letters held, 0..3
- result  out  6  2 bits per position, pos1 in [5:4]: 00 miss, 01 present elsewhere, 10 exact
- guess_num  out  3  completed guesses
- win  out  1  high in WIN
- lose  out  1  high in LOSE

Behaviour:
- Reset (rst=0, async): state=ENTRY; all outputs 0; edge-detect history regs 0.
- Edge detect: registered previous level per button; rising edge = level & ~prev.
- All outputs are registered. An edge sampled at cycle n produces its pulse in cycle n+1.
- States: ENTRY, CHECK, WIN, LOSE.
- ENTRY, en edge with letter_count<3: dec_en=1, count+1.
- ENTRY, en edge at count=3: ignored, no pulse.
- ENTRY, del edge with count>0: dec_del=1, count-1.
- ENTRY, del edge at count=0: ignored, no pulse.
- ENTRY, en and del edges in the same cycle: del wins, en dropped.
- ENTRY, submit edge at count=3: go to CHECK. Submit edge at count<3: ignored.
- CHECK (exactly 1 cycle): score letter1..3 against target.
  - exact[i] = guess[i]==target[i].
  - present[i] = !exact[i] and guess[i]==target[j] for some j≠i with !exact[j].
  - result registered at the CHECK→next transition.
  - guess_num+1 (saturating at 7).
- CHECK exit:
  - all exact → WIN.
  - else if new guess_num==MAX_GUESSES → LOSE.
  - else → ENTRY with dec_clr=1 and count=0 in that cycle.
- Latency: submit edge at cycle n → CHECK at n+1 → result/state valid at n+2.
- result holds until the next CHECK or new game.
- WIN/LOSE: en/del ignored. Submit edge → ENTRY with dec_clr=1, count=0, guess_num=0, result=0, win=lose=0.
- Buttons held high produce only one event (edge-based).
- Reset mid-CHECK: async clear as above. Decoder reset is the top level's responsibility.
- dec_en, dec_del and dec_clr are never asserted in the same cycle.

Decomposition:
- Shared package:
  - state encoding constants (ENTRY=2'd0, CHECK=2'd1, WIN=2'd2, LOSE=2'd3)
  - result codes (MISS=2'b00, PRESENT=2'b01, EXACT=2'b10)
  - LETTER_W default
- One natural sub-module: guess_scorer, purely combinational. Takes guess and target (18b each) and returns result (6b).
- Edge detectors stay inline.

Test Plan:
- Reset, then three en edges with switches 13,19,19 (M,S,S) → three single-cycle dec_en pulses, letter_count 1,2,3; fourth en edge → no dec_en, count stays 3.
- count=3, del edge → dec_del pulse, count=2. Three more del edges → two pulses, then ignored at 0. Same-cycle en+del edges → dec_del only.
- target=C,A,T (3,1,20), guess A,C,T (1,3,20), submit → CHECK next cycle. Two cycles after edge: result=6'b010110, guess_num=1, dec_clr pulse, count=0.
- Guess C,A,T → result=6'b101010, win=1. Subsequent en/del edges → no pulses. Submit → win=0, guess_num=0, dec_clr pulse.
- MAX_GUESSES=2, two wrong guesses (M,S,S → result 000000) → lose=1 after second CHECK, guess_num=2.
- Submit with count=2 → no state change. Assert rst low during CHECK → all outputs 0 immediately, ENTRY after release.
